spi_byte_engine: RTL and testbench

SPI_BYTE_ENGINE -- requirements
Module: spi_byte_engine

---
 rtl/gigatron_ext_pkg.sv | 16 +
 rtl/spi_clkdiv.sv | 29 ++
 rtl/spi_byte_engine.sv | 136 +++++++++++++
 tb/tb_spi_byte_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gigatron_ext_pkg.sv
// Shared definitions for the Gigatron expansion peripherals: SPI engine
// state encoding and default divider width.
package gigatron_ext_pkg;

    localparam int SPI_DIVW_DEFAULT = 2;

    localparam logic [2:0] SPI_LAST_BIT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_FIN  = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period down-counter for the SPI engine: reloads with div and
// reports expiry once it has counted down to zero.
module spi_clkdiv
    import gigatron_ext_pkg::*;
#(
    parameter int DIVW = SPI_DIVW_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            reload,
    input  logic [DIVW-1:0] div,
    output logic            expire
);

    logic [DIVW-1:0] r_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (reload) begin
            r_count <= div;
        end else if (r_count != '0) begin
            r_count <= r_count - DIVW'(1);
        end
    end

    assign expire = (r_count == '0);

endmodule

// File: rtl/spi_byte_engine.sv
// Mode-0 SPI master that shifts one byte MSB first per START, with a
// programmable SCK half-period and registered slave selects.
module spi_byte_engine
    import gigatron_ext_pkg::*;
#(
    parameter int DIVW = SPI_DIVW_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic            ABORT,
    input  logic [7:0]      TXDATA,
    input  logic [DIVW-1:0] DIV,
    input  logic [1:0]      SSEL,
    input  logic            MISO,
    output logic            SCK,
    output logic            MOSI,
    output logic [1:0]      nSS,
    output logic [7:0]      RXDATA,
    output logic            BUSY,
    output logic            DONE
);

    spi_state_t      r_state;
    logic [7:0]      r_shift;
    logic            r_rx_bit;
    logic [2:0]      r_bitcnt;
    logic [DIVW-1:0] r_div;
    logic            r_sck;
    logic            r_mosi;
    logic [1:0]      r_nss;
    logic [7:0]      r_rxdata;
    logic            r_busy;
    logic            r_done;

    logic            w_start_ok;
    logic            w_expire;
    logic            w_reload;
    logic [DIVW-1:0] w_div_sel;

    assign w_start_ok = (r_state == ST_IDLE) && START && !ABORT;
    assign w_reload   = w_start_ok ||
                        (!ABORT && w_expire && (r_state == ST_LOW || r_state == ST_HIGH));
    // The first reload happens on the accepting edge, before r_div holds the new value.
    assign w_div_sel  = (r_state == ST_IDLE) ? DIV : r_div;

    spi_clkdiv #(
        .DIVW   (DIVW)
    ) u_clkdiv (
        .CLK    (CLK),
        .RST    (RST),
        .reload (w_reload),
        .div    (w_div_sel),
        .expire (w_expire)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_rx_bit <= 1'b0;
            r_bitcnt <= '0;
            r_div    <= '0;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
            r_nss    <= 2'b11;
            r_rxdata <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_nss <= SSEL;
                    if (w_start_ok) begin
                        r_state  <= ST_LOW;
                        r_shift  <= TXDATA;
                        r_mosi   <= TXDATA[7];
                        r_bitcnt <= '0;
                        r_div    <= DIV;
                        r_busy   <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (ABORT) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_expire) begin
                        r_state  <= ST_HIGH;
                        r_sck    <= 1'b1;
                        r_rx_bit <= MISO;
                    end
                end
                ST_HIGH: begin
                    // Sampled bit is held aside so the untransmitted LSBs survive until shifted out.
                    if (ABORT) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_sck   <= 1'b0;
                    end else if (w_expire) begin
                        r_sck <= 1'b0;
                        if (r_bitcnt == SPI_LAST_BIT) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_state  <= ST_LOW;
                            r_shift  <= {r_shift[6:0], r_rx_bit};
                            r_mosi   <= r_shift[6];
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (!ABORT) begin
                        r_rxdata <= {r_shift[6:0], r_rx_bit};
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_sck   <= 1'b0;
                end
            endcase
        end
    end

    assign SCK    = r_sck;
    assign MOSI   = r_mosi;
    assign nSS    = r_nss;
    assign RXDATA = r_rxdata;
    assign BUSY   = r_busy;
    assign DONE   = r_done;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Self-checking bench for spi_byte_engine: transaction-level model of the
// transfer timeline plus directed scenarios and randomized traffic.
module tb_spi_byte_engine;

    localparam int DIVW = 2;

    logic            CLK    = 1'b0;
    logic            RST    = 1'b1;
    logic            START  = 1'b0;
    logic            ABORT  = 1'b0;
    logic [7:0]      TXDATA = 8'h00;
    logic [DIVW-1:0] DIV    = '0;
    logic [1:0]      SSEL   = 2'b11;
    logic            MISO   = 1'b0;
    logic            SCK;
    logic            MOSI;
    logic [1:0]      nSS;
    logic [7:0]      RXDATA;
    logic            BUSY;
    logic            DONE;

    spi_byte_engine #(.DIVW(DIVW)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .ABORT  (ABORT),
        .TXDATA (TXDATA),
        .DIV    (DIV),
        .SSEL   (SSEL),
        .MISO   (MISO),
        .SCK    (SCK),
        .MOSI   (MOSI),
        .nSS    (nSS),
        .RXDATA (RXDATA),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Transaction model: a transfer is described only by its age in cycles
    // since the accepting edge; L = 16*(DIV+1) cycles of clocking, then FIN.
    bit         m_active = 1'b0;
    int         m_age    = 0;
    int         m_div    = 0;
    logic [7:0] m_tx     = 8'h00;
    logic [7:0] m_exp_rx = 8'h00;
    logic [7:0] m_rx     = 8'h00;
    logic [1:0] m_nss    = 2'b11;

    bit         miso_mode  = 1'b0;   // 0: loopback, 1: slave returns slave_byte
    logic [7:0] slave_byte = 8'h00;

    always @(posedge CLK or posedge RST) begin
        int lim;
        if (RST) begin
            m_active = 1'b0;
            m_age    = 0;
            m_rx     = 8'h00;
            m_nss    = 2'b11;
        end else begin
            lim = 16 * (m_div + 1);
            if (m_active && m_age <= lim) begin
                if (ABORT) begin
                    m_active = 1'b0;
                end else begin
                    m_age = m_age + 1;
                    if (m_age == lim + 1) m_rx = m_exp_rx;
                end
            end else begin
                m_active = 1'b0;
                m_nss    = SSEL;
                if (START && !ABORT) begin
                    m_active = 1'b1;
                    m_age    = 0;
                    m_div    = int'(DIV);
                    m_tx     = TXDATA;
                    m_exp_rx = miso_mode ? slave_byte : TXDATA;
                end
            end
        end
    end

    // Slave: loops MOSI back, or presents slave_byte MSB first, advancing on SCK falls.
    int   fall_cnt = 0;
    logic sck_q    = 1'b0;
    always @(negedge CLK) begin
        if (!BUSY) fall_cnt = 0;
        else if (sck_q && !SCK) fall_cnt = fall_cnt + 1;
        sck_q = SCK;
        if (!miso_mode) MISO = MOSI;
        else if (fall_cnt < 8) MISO = slave_byte[7 - fall_cnt];
        else MISO = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: wait for the falling edge and compare all outputs to the model.
    task automatic cyc();
        int   lim;
        logic e_busy, e_sck, e_done;
        @(negedge CLK);
        lim    = 16 * (m_div + 1);
        e_busy = m_active && (m_age <= lim);
        e_sck  = e_busy && (m_age < lim) && (((m_age / (m_div + 1)) % 2) == 1);
        e_done = m_active && (m_age == lim + 1);
        chk("sck", SCK, e_sck);
        chk("busy", BUSY, e_busy);
        chk("done", DONE, e_done);
        chk("rxdata", RXDATA, m_rx);
        chk("nss", nSS, m_nss);
        if (e_busy && m_age < lim)
            chk("mosi", MOSI, m_tx[7 - m_age / (2 * (m_div + 1))]);
    endtask

    int         inject_at = -1;
    logic [7:0] inject_tx = 8'h00;
    int         abort_at  = -1;
    int         ssel_at   = -1;
    logic [1:0] ssel_new  = 2'b11;
    bit         rand_ssel = 1'b0;

    int         done_at, done_cnt, rise_cnt;
    int         hi_min, hi_max, lo_min, lo_max;
    logic [7:0] mosi_seen;
    logic       busy_hist [0:127];
    logic       sck_hist  [0:127];
    logic [1:0] nss_hist  [0:127];

    task automatic clear_events();
        inject_at = -1;
        abort_at  = -1;
        ssel_at   = -1;
    endtask

    task automatic start_xfer(input int d, input logic [7:0] tx, input logic [1:0] ss,
                              input bit mode, input logic [7:0] slv, input bit both);
        DIV        = DIVW'(d);
        TXDATA     = tx;
        SSEL       = ss;
        miso_mode  = mode;
        slave_byte = slv;
        START      = 1'b1;
        ABORT      = both;
    endtask

    // Runs n cycles (sample k is k cycles after the START edge) and records observations.
    task automatic watch(input int n);
        int   hi_run, lo_run;
        logic prev_sck;
        done_at = -1; done_cnt = 0; rise_cnt = 0; mosi_seen = 8'h00;
        hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
        hi_run = 0; lo_run = 0; prev_sck = 1'b0;
        for (int k = 0; k < n; k++) begin
            cyc();
            if (k < 128) begin
                busy_hist[k] = BUSY;
                sck_hist[k]  = SCK;
                nss_hist[k]  = nSS;
            end
            if (DONE) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (SCK) begin
                if (!prev_sck) begin
                    mosi_seen = {mosi_seen[6:0], MOSI};
                    rise_cnt++;
                    if (lo_run > 0) begin
                        if (lo_run < lo_min) lo_min = lo_run;
                        if (lo_run > lo_max) lo_max = lo_run;
                    end
                end
                lo_run = 0;
                hi_run++;
            end else begin
                if (prev_sck) begin
                    if (hi_run < hi_min) hi_min = hi_run;
                    if (hi_run > hi_max) hi_max = hi_run;
                end
                hi_run = 0;
                if (BUSY) lo_run++;
            end
            prev_sck = SCK;
            START = (k == inject_at);
            if (k == inject_at) TXDATA = inject_tx;
            ABORT = (k == abort_at);
            if (k == ssel_at) SSEL = ssel_new;
            else if (rand_ssel) SSEL = 2'($urandom);
        end
        START = 1'b0;
        ABORT = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (i < 300 && m_active && m_age <= 16 * (m_div + 1) + 1) begin
            cyc();
            i++;
        end
        if (i >= 300) chk("idle_timeout", 32'd1, 32'd0);
        cyc();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, n;

        cyc(); cyc();
        chk("rst_sck", SCK, 1'b0);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_nss", nSS, 2'b11);
        chk("rst_rx", RXDATA, 8'h00);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        RST = 1'b0;
        cyc();

        // Loopback A5 at DIV=0
        clear_events();
        start_xfer(0, 8'hA5, 2'b10, 1'b0, 8'h00, 1'b0);
        watch(20);
        chk("a5_mosi_bits", mosi_seen, 8'hA5);
        chk("a5_rises", rise_cnt, 8);
        chk("a5_rx", RXDATA, 8'hA5);
        chk("a5_done_at", done_at, 17);
        chk("a5_done_cnt", done_cnt, 1);

        // Slave returns C3 at DIV=3
        start_xfer(3, 8'h3C, 2'b01, 1'b1, 8'hC3, 1'b0);
        watch(68);
        chk("c3_mosi_bits", mosi_seen, 8'h3C);
        chk("c3_rx", RXDATA, 8'hC3);
        chk("c3_done_at", done_at, 65);
        chk("c3_hi_min", hi_min, 4);
        chk("c3_hi_max", hi_max, 4);
        chk("c3_lo_min", lo_min, 4);
        chk("c3_lo_max", lo_max, 4);

        // Second START while busy is ignored
        start_xfer(0, 8'h96, 2'b10, 1'b0, 8'h00, 1'b0);
        inject_at = 4; inject_tx = 8'h11;
        watch(24);
        clear_events();
        chk("ign_done_cnt", done_cnt, 1);
        chk("ign_done_at", done_at, 17);
        chk("ign_rx", RXDATA, 8'h96);
        wait_idle();

        // ABORT at cycle 7
        start_xfer(0, 8'h5A, 2'b10, 1'b0, 8'h00, 1'b0);
        watch(20);
        chk("pre_abort_rx", RXDATA, 8'h5A);
        start_xfer(0, 8'hC7, 2'b10, 1'b0, 8'h00, 1'b0);
        abort_at = 6;
        watch(24);
        clear_events();
        chk("abort_sck_before", sck_hist[5], 1'b1);
        chk("abort_busy_before", busy_hist[6], 1'b1);
        chk("abort_busy_after", busy_hist[7], 1'b0);
        chk("abort_sck_after", sck_hist[7], 1'b0);
        chk("abort_done_cnt", done_cnt, 0);
        chk("abort_rx", RXDATA, 8'h5A);

        // RST pulse at cycle 9
        start_xfer(0, 8'h66, 2'b10, 1'b0, 8'h00, 1'b0);
        watch(9);
        #2 RST = 1'b1;
        #1;
        chk("arst_nss", nSS, 2'b11);
        chk("arst_rx", RXDATA, 8'h00);
        chk("arst_busy", BUSY, 1'b0);
        chk("arst_sck", SCK, 1'b0);
        cyc();
        RST = 1'b0;
        watch(20);
        chk("arst_no_done", done_cnt, 0);
        chk("arst_rx_after", RXDATA, 8'h00);
        start_xfer(1, 8'hFF, 2'b10, 1'b0, 8'h00, 1'b0);
        watch(36);
        chk("ff_done_at", done_at, 33);
        chk("ff_rx", RXDATA, 8'hFF);

        // SSEL change during BUSY is held until after DONE
        start_xfer(0, 8'h4B, 2'b10, 1'b0, 8'h00, 1'b0);
        ssel_at = 3; ssel_new = 2'b01;
        watch(22);
        clear_events();
        chk("ssel_mid", nss_hist[5], 2'b10);
        chk("ssel_at_done", nss_hist[17], 2'b10);
        chk("ssel_after_done", nss_hist[18], 2'b01);

        // START together with ABORT in IDLE does not start
        start_xfer(0, 8'h33, 2'b11, 1'b0, 8'h00, 1'b1);
        watch(5);
        chk("start_abort_busy", busy_hist[0], 1'b0);

        // Back-to-back: START in the DONE cycle
        start_xfer(0, 8'h21, 2'b10, 1'b0, 8'h00, 1'b0);
        inject_at = 17; inject_tx = 8'h84;
        watch(40);
        clear_events();
        chk("b2b_done_cnt", done_cnt, 2);
        chk("b2b_rx", RXDATA, 8'h84);

        // Randomized traffic checked cycle by cycle against the model
        rand_ssel = 1'b1;
        for (int t = 0; t < 120; t++) begin
            d = $urandom_range(0, 3);
            n = 16 * (d + 1) + 2 + $urandom_range(0, 3);
            clear_events();
            if ($urandom_range(0, 3) == 0) abort_at = $urandom_range(0, 16 * (d + 1));
            if ($urandom_range(0, 2) == 0) begin
                inject_at = $urandom_range(0, n - 1);
                inject_tx = 8'($urandom);
            end
            start_xfer(d, 8'($urandom), 2'($urandom), 1'($urandom), 8'($urandom),
                       ($urandom_range(0, 9) == 0));
            watch(n);
            wait_idle();
        end
        rand_ssel = 1'b0;
        clear_events();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
